// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module : maze_pkg
// Brief  : Shared maze dimensions, row type and loader state encoding.
// Rev    : 1.0
// ============================================================================
package maze_pkg;

    localparam int MAZE_SIZE_Y = 20;
    localparam int MAZE_SIZE_X = 40;

    // Bit [0] is the leftmost column; 1 = wall, 0 = open.
    typedef logic [0:MAZE_SIZE_X-1] row_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/maze_row_loader_if.sv
`default_nettype none
// ============================================================================
// Module : maze_row_loader_if
// Brief  : Row stream from the level source into the maze loader.
// Rev    : 1.0
// ============================================================================
interface maze_row_loader_if
    import maze_pkg::*;
#(
    parameter int SIZE_X = MAZE_SIZE_X
);

    logic                start;
    logic [0:SIZE_X-1]   row_data;
    logic                row_valid;
    logic                row_ready;

    modport master (
        output start,
        output row_data,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  start,
        input  row_data,
        input  row_valid,
        output row_ready
    );

endinterface
`default_nettype wire

// File: rtl/maze_row_buffer.sv
`default_nettype none
// ============================================================================
// Module : maze_row_buffer
// Brief  : Shadow grid store; single-row indexed write, full-grid read.
// Rev    : 1.0
// ============================================================================
module maze_row_buffer
    import maze_pkg::*;
#(
    parameter int SIZE_Y = MAZE_SIZE_Y,
    parameter int SIZE_X = MAZE_SIZE_X,
    parameter int IDX_W  = 5
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_we,
    input  wire logic [IDX_W-1:0]    i_idx,
    input  wire logic [0:SIZE_X-1]   i_row,
    output logic      [0:SIZE_X-1]   o_grid [SIZE_Y-1:0]
);

    logic [0:SIZE_X-1] r_mem [SIZE_Y-1:0];

    // Per-row compare keeps out-of-range indices harmless for non-power-of-2 heights.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE_Y; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE_Y; i++) begin
                if (i_we && (i_idx == IDX_W'(i))) begin
                    r_mem[i] <= i_row;
                end
            end
        end
    end

    assign o_grid = r_mem;

endmodule
`default_nettype wire

// File: rtl/maze_row_loader.sv
`default_nettype none
// ============================================================================
// Module : maze_row_loader
// Brief  : Loads a maze row by row into a shadow buffer, commits atomically.
// Rev    : 1.0
// ============================================================================
module maze_row_loader
    import maze_pkg::*;
#(
    parameter int SIZE_Y = MAZE_SIZE_Y,
    parameter int SIZE_X = MAZE_SIZE_X
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    maze_row_loader_if.slave   row_if,
    output logic [0:SIZE_X-1]  maze [SIZE_Y-1:0],
    output logic               maze_valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SIZE_Y - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [IDX_W-1:0]  r_row_idx;
    logic [IDX_W-1:0]  w_row_idx_nxt;
    logic              w_accept;
    logic              w_commit;
    logic              w_row_ready;

    logic [0:SIZE_X-1] w_shadow [SIZE_Y-1:0];
    logic [0:SIZE_X-1] r_maze   [SIZE_Y-1:0];
    logic              r_maze_valid;
    logic              r_done;

    maze_row_buffer #(
        .SIZE_Y (SIZE_Y),
        .SIZE_X (SIZE_X),
        .IDX_W  (IDX_W)
    ) u_buffer (
        .clk    (Clk),
        .rst    (Reset),
        .i_we   (w_accept),
        .i_idx  (r_row_idx),
        .i_row  (row_if.row_data),
        .o_grid (w_shadow)
    );

    // A start pulse in LOAD rewinds the index and blocks acceptance that cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_row_ready   = 1'b0;
        w_accept      = 1'b0;
        w_commit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (row_if.start) begin
                    w_state_nxt   = ST_LOAD;
                    w_row_idx_nxt = '0;
                end
            end
            ST_LOAD: begin
                w_row_ready = ~row_if.start;
                if (row_if.start) begin
                    w_row_idx_nxt = '0;
                end else if (row_if.row_valid) begin
                    w_accept = 1'b1;
                    if (r_row_idx == c_LAST_IDX) begin
                        w_state_nxt = ST_COMMIT;
                    end else begin
                        w_row_idx_nxt = r_row_idx + c_IDX_ONE;
                    end
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_row_idx    <= '0;
            r_maze_valid <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < SIZE_Y; i++) begin
                r_maze[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_done    <= w_commit;
            if (w_commit) begin
                r_maze       <= w_shadow;
                r_maze_valid <= 1'b1;
            end
        end
    end

    assign row_if.row_ready = w_row_ready;
    assign maze             = r_maze;
    assign maze_valid       = r_maze_valid;
    assign busy             = (r_state != ST_IDLE);
    assign done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_maze_row_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_maze_row_loader
// Brief  : Directed checks of the maze row loader at 4x8 and at 20x40.
// Rev    : 1.0
// ============================================================================
module tb_maze_row_loader;
    import maze_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s;
    logic rst_d;

    maze_row_loader_if #(.SIZE_X(8))  s_if ();
    maze_row_loader_if #(.SIZE_X(40)) d_if ();

    logic [0:7]  maze_s [3:0];
    logic        mv_s, busy_s, done_s;
    logic [0:39] maze_d [19:0];
    logic        mv_d, busy_d, done_d;

    maze_row_loader #(.SIZE_Y(4), .SIZE_X(8)) dut_s (
        .Clk        (clk),
        .Reset      (rst_s),
        .row_if     (s_if),
        .maze       (maze_s),
        .maze_valid (mv_s),
        .busy       (busy_s),
        .done       (done_s)
    );

    maze_row_loader #(.SIZE_Y(20), .SIZE_X(40)) dut_d (
        .Clk        (clk),
        .Reset      (rst_d),
        .row_if     (d_if),
        .maze       (maze_d),
        .maze_valid (mv_d),
        .busy       (busy_d),
        .done       (done_d)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        mv;
        logic [31:0] mz;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mz_s();
        return {maze_s[0], maze_s[1], maze_s[2], maze_s[3]};
    endfunction

    task automatic step_s(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        s_if.start     = st;
        s_if.row_valid = v;
        s_if.row_data  = d;
        #1;
    endtask

    // Full back-to-back load; optionally pulses start during COMMIT (must be ignored).
    task automatic load_s(input logic [31:0] rows, input logic start_in_commit);
        step_s(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step_s(1'b0, 1'b1, rows[31-8*i -: 8]);
            chk("load_ready", {63'd0, s_if.row_ready}, 64'd1);
        end
        step_s(start_in_commit, 1'b0, 8'h00);
        chk("load_commit_busy", {63'd0, busy_s}, 64'd1);
        chk("load_commit_done", {63'd0, done_s}, 64'd0);
        step_s(1'b0, 1'b0, 8'h00);
        chk("load_done", {63'd0, done_s}, 64'd1);
        chk("load_busy_low", {63'd0, busy_s}, 64'd0);
        chk("load_maze", {32'd0, mz_s()}, {32'd0, rows});
        chk("load_mv", {63'd0, mv_s}, 64'd1);
    endtask

    initial begin
        logic [0:39] sb [20];
        logic [39:0] r;
        int acc, dn, extra, cyc;

        tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[1] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[2] = '{1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[3] = '{1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[4] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[5] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tv[6] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFF8181FF};
        tv[7] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFF8181FF};

        rst_s = 1'b1;
        rst_d = 1'b1;
        s_if.start = 1'b0; s_if.row_valid = 1'b0; s_if.row_data = '0;
        d_if.start = 1'b0; d_if.row_valid = 1'b0; d_if.row_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_maze", {32'd0, mz_s()}, 64'd0);
        chk("rst_mv", {63'd0, mv_s}, 64'd0);
        chk("rst_busy", {63'd0, busy_s}, 64'd0);
        chk("rst_ready", {63'd0, s_if.row_ready}, 64'd0);
        chk("rst_done", {63'd0, done_s}, 64'd0);
        chk("rst_d_mv", {63'd0, mv_d}, 64'd0);
        chk("rst_d_maze0", {24'd0, maze_d[0]}, 64'd0);
        @(negedge clk);
        rst_s = 1'b0;
        rst_d = 1'b0;
        step_s(1'b0, 1'b1, 8'h33);
        chk("idle_busy", {63'd0, busy_s}, 64'd0);
        chk("idle_ready", {63'd0, s_if.row_ready}, 64'd0);
        chk("idle_maze", {32'd0, mz_s()}, 64'd0);

        // Basic load, cycle-accurate table.
        for (int i = 0; i < 8; i++) begin
            step_s(tv[i].st, tv[i].v, tv[i].d);
            chk($sformatf("tv%0d_ready", i), {63'd0, s_if.row_ready}, {63'd0, tv[i].rdy});
            chk($sformatf("tv%0d_busy", i),  {63'd0, busy_s}, {63'd0, tv[i].bsy});
            chk($sformatf("tv%0d_done", i),  {63'd0, done_s}, {63'd0, tv[i].dn});
            chk($sformatf("tv%0d_mv", i),    {63'd0, mv_s}, {63'd0, tv[i].mv});
            chk($sformatf("tv%0d_maze", i),  {32'd0, mz_s()}, {32'd0, tv[i].mz});
        end

        // Same load with a 3-cycle stall after row 0: done moves from t+6 to t+9.
        step_s(1'b1, 1'b0, 8'h00);
        step_s(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step_s(1'b0, 1'b0, 8'h00);
            chk("stall_ready", {63'd0, s_if.row_ready}, 64'd1);
            chk("stall_done", {63'd0, done_s}, 64'd0);
        end
        step_s(1'b0, 1'b1, 8'h81);
        step_s(1'b0, 1'b1, 8'h81);
        step_s(1'b0, 1'b1, 8'hFF);
        chk("stall_old_maze", {32'd0, mz_s()}, 64'hFF8181FF);
        step_s(1'b0, 1'b0, 8'h00);
        chk("stall_t8_done", {63'd0, done_s}, 64'd0);
        step_s(1'b0, 1'b0, 8'h00);
        chk("stall_t9_done", {63'd0, done_s}, 64'd1);
        chk("stall_maze", {32'd0, mz_s()}, 64'hFF8181FF);

        // Restart: A committed, partial B, restart with C.
        load_s(32'h01020408, 1'b0);
        step_s(1'b1, 1'b0, 8'h00);
        step_s(1'b0, 1'b1, 8'hAA);
        step_s(1'b0, 1'b1, 8'hBB);
        chk("rs_maze_a", {32'd0, mz_s()}, 64'h01020408);
        step_s(1'b1, 1'b1, 8'hCC);
        chk("rs_restart_ready", {63'd0, s_if.row_ready}, 64'd0);
        step_s(1'b0, 1'b1, 8'h10);
        step_s(1'b0, 1'b1, 8'h20);
        step_s(1'b0, 1'b1, 8'h40);
        step_s(1'b0, 1'b1, 8'h80);
        chk("rs_maze_a_late", {32'd0, mz_s()}, 64'h01020408);
        chk("rs_mv_kept", {63'd0, mv_s}, 64'd1);
        step_s(1'b0, 1'b0, 8'h00);
        chk("rs_commit_done", {63'd0, done_s}, 64'd0);
        step_s(1'b1, 1'b0, 8'h00);
        chk("rs_done", {63'd0, done_s}, 64'd1);
        chk("rs_maze_c", {32'd0, mz_s()}, 64'h10204080);
        step_s(1'b0, 1'b0, 8'h00);
        chk("rs_single_done", {63'd0, done_s}, 64'd0);
        chk("rs_start_at_done_busy", {63'd0, busy_s}, 64'd1);
        chk("rs_start_at_done_ready", {63'd0, s_if.row_ready}, 64'd1);

        // Reset mid-load after two rows.
        step_s(1'b0, 1'b1, 8'h11);
        step_s(1'b0, 1'b1, 8'h22);
        @(negedge clk);
        rst_s = 1'b1;
        s_if.row_data = 8'h33;
        @(negedge clk);
        rst_s = 1'b0;
        #1;
        chk("mrst_maze", {32'd0, mz_s()}, 64'd0);
        chk("mrst_mv", {63'd0, mv_s}, 64'd0);
        chk("mrst_ready", {63'd0, s_if.row_ready}, 64'd0);
        chk("mrst_busy", {63'd0, busy_s}, 64'd0);
        load_s(32'h3C5A0FF0, 1'b1);

        // 20x40 load with random row_valid gaps.
        acc = 0; dn = 0; extra = 0; cyc = 0;
        @(negedge clk);
        d_if.start = 1'b1;
        d_if.row_valid = 1'b0;
        while (acc < 20 && cyc < 400) begin
            @(negedge clk);
            r = {8'($urandom), 32'($urandom)};
            d_if.start     = 1'b0;
            d_if.row_valid = 1'($urandom_range(0, 1));
            d_if.row_data  = r;
            #1;
            if (done_d) dn++;
            if (d_if.row_valid && d_if.row_ready) begin
                sb[acc] = r;
                acc++;
            end
            cyc++;
        end
        chk("big_accepted", 64'(acc), 64'd20);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d_if.row_valid = 1'b1;
            d_if.row_data  = {8'($urandom), 32'($urandom)};
            #1;
            if (done_d) dn++;
            if (d_if.row_ready) extra++;
        end
        chk("big_done_count", 64'(dn), 64'd1);
        chk("big_extra_rows", 64'(extra), 64'd0);
        chk("big_mv", {63'd0, mv_d}, 64'd1);
        chk("big_busy", {63'd0, busy_d}, 64'd0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("big_row%0d", i), {24'd0, maze_d[i]}, {24'd0, sb[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
